// File: rtl/remap_table_readback.sv
// rtl/remap_table_readback.sv - scans the remap table and streams it out as packed 32-bit words
module remap_table_readback #(
    parameter int N_ENTRIES = 128,
    parameter int ENTRY_W   = 7
) (
    input  logic               okClk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic [6:0]         rd_addr,
    input  logic [ENTRY_W-1:0] rd_data,
    output logic [31:0]        out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic [5:0]         word_count,
    output logic [31:0]        checksum
);

    localparam int         N_WORDS   = N_ENTRIES / 4;
    localparam logic [6:0] LAST_ADDR = 7'(N_ENTRIES - 1);
    localparam logic [5:0] WC_MAX    = 6'(N_WORDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [6:0]  rd_addr_q, rd_addr_d;
    // phase 0..2 advance the address, phases 1..4 capture bytes 0..3
    logic [2:0]  phase_q, phase_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic [5:0]  word_count_q, word_count_d;
    logic [31:0] checksum_q, checksum_d;
    logic [7:0]  byte_w;
    logic [1:0]  lane_w;

    assign byte_w = 8'(rd_data);
    assign lane_w = phase_q[1:0] - 2'd1;

    // next-state logic: abort wins over everything except reset, then the normal walk
    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        phase_d      = phase_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        word_count_d = word_count_q;
        checksum_d   = checksum_q;
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d      = S_FETCH;
                        rd_addr_d    = 7'd0;
                        phase_d      = 3'd0;
                        word_count_d = 6'd0;
                        checksum_d   = 32'd0;
                    end
                end
                S_FETCH: begin
                    if (phase_q < 3'd3) begin
                        rd_addr_d = rd_addr_q + 7'd1;
                    end
                    if (phase_q != 3'd0) begin
                        out_data_d[{lane_w, 3'b000} +: 8] = byte_w;
                    end
                    if (phase_q == 3'd4) begin
                        state_d     = S_SEND;
                        out_valid_d = 1'b1;
                        phase_d     = 3'd0;
                    end else begin
                        phase_d = phase_q + 3'd1;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        checksum_d  = checksum_q ^ out_data_q;
                        if (word_count_q != WC_MAX) begin
                            word_count_d = word_count_q + 6'd1;
                        end
                        if (rd_addr_q == LAST_ADDR) begin
                            state_d = S_DONE;
                        end else begin
                            state_d   = S_FETCH;
                            rd_addr_d = rd_addr_q + 7'd1;
                            phase_d   = 3'd0;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // state registers with synchronous active-high reset
    always_ff @(posedge okClk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rd_addr_q    <= 7'd0;
            phase_q      <= 3'd0;
            out_data_q   <= 32'd0;
            out_valid_q  <= 1'b0;
            word_count_q <= 6'd0;
            checksum_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            phase_q      <= phase_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            word_count_q <= word_count_d;
            checksum_q   <= checksum_d;
        end
    end

    assign rd_addr    = rd_addr_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign word_count = word_count_q;
    assign checksum   = checksum_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule
